// File: rtl/gc_dram_retention_array_pkg.sv
// Shared defaults and row/address/counter types for the gain-cell DRAM retention macro.
package gc_dram_pkg;
    localparam int DATA_W_DEF      = 64;
    localparam int DEPTH_DEF       = 128;
    localparam int RET_CYCLES_DEF  = 50;
    localparam int WARN_MARGIN_DEF = 8;
    localparam int ADDR_W_DEF      = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF       = $clog2(RET_CYCLES_DEF + 1);

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [CNT_W_DEF-1:0]  cnt_t;
    typedef logic [DATA_W_DEF-1:0] row_t;
endpackage

// File: rtl/gc_dram_retention_array_if.sv
// Bus between the refresh controller (master) and the retention macro (slave).
interface gc_dram_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7
);
    // All requests (we, re, ref_en) are single-cycle strobes sampled on posedge clk with
    // no backpressure: every strobe is accepted, and each re/ref_en yields exactly one
    // response pulse (rd_valid|rd_expired, ref_done) on the following edge.
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rd;
    logic              rd_valid;
    logic              rd_expired;
    logic              ref_en;
    logic [ADDR_W-1:0] ref_addr;
    logic              ref_done;
    logic              ref_ok;
    logic [ADDR_W:0]   live_cnt;
    logic              warn;
    logic [ADDR_W-1:0] warn_addr;

    modport master (
        output we, waddr, wdata, re, raddr, ref_en, ref_addr,
        input  rd, rd_valid, rd_expired, ref_done, ref_ok, live_cnt, warn, warn_addr
    );
    modport slave (
        input  we, waddr, wdata, re, raddr, ref_en, ref_addr,
        output rd, rd_valid, rd_expired, ref_done, ref_ok, live_cnt, warn, warn_addr
    );
endinterface

// File: rtl/gc_dram_retention_array_row_timer.sv
// Per-row retention counter: reload on write or on refresh of a live row, else count down to 0.
module gc_dram_row_timer #(
    parameter int RET_CYCLES  = 50,
    parameter int CNT_W       = 6,
    parameter int WARN_MARGIN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic refresh_i,
    output logic live_o,
    output logic live_d_o,
    output logic near_d_o,
    output logic expire_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(RET_CYCLES);
        end else if (refresh_i && (cnt_q != '0)) begin
            cnt_d = CNT_W'(RET_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // live_o is pre-edge liveness (what reads see); the _d outputs describe the post-edge state.
    assign live_o   = (cnt_q != '0);
    assign live_d_o = (cnt_d != '0);
    assign near_d_o = live_d_o && (cnt_d <= CNT_W'(WARN_MARGIN));
    assign expire_o = live_o && !live_d_o;
endmodule

// File: rtl/gc_dram_retention_array.sv
// Gain-cell DRAM macro with per-row retention timers, read port, refresh port and live count.
// Optional near-expiry scan enabled by defining GC_DRAM_RET_WARN_EN.
module gc_dram_retention_array
    import gc_dram_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int RET_CYCLES  = RET_CYCLES_DEF,
    parameter int CNT_W       = $clog2(RET_CYCLES + 1),
    parameter int WARN_MARGIN = WARN_MARGIN_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    gc_dram_if.slave bus
);
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(DEPTH);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  live, live_d, near_d, expire;
    logic              wr_hit, ref_hit;
    logic [DATA_W-1:0] rd_q;
    logic              rd_valid_q, rd_expired_q, ref_done_q, ref_ok_q;
    logic [ADDR_W:0]   live_cnt_q, live_cnt_d;

    assign wr_hit  = bus.we && in_range(bus.waddr);
    assign ref_hit = bus.ref_en && in_range(bus.ref_addr);

    for (genvar g = 0; g < DEPTH; g++) begin : g_row
        gc_dram_row_timer #(
            .RET_CYCLES (RET_CYCLES),
            .CNT_W      (CNT_W),
            .WARN_MARGIN(WARN_MARGIN)
        ) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (wr_hit && (bus.waddr == ADDR_W'(g))),
            .refresh_i(ref_hit && (bus.ref_addr == ADDR_W'(g))),
            .live_o   (live[g]),
            .live_d_o (live_d[g]),
            .near_d_o (near_d[g]),
            .expire_o (expire[g])
        );
    end

    // Expiring rows lose their contents; a write to the same row reloads it so never expires.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (expire[i]) mem[i] <= 'x;
        end
        if (wr_hit) mem[bus.waddr] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q         <= '0;
            rd_valid_q   <= 1'b0;
            rd_expired_q <= 1'b0;
            ref_done_q   <= 1'b0;
            ref_ok_q     <= 1'b0;
            live_cnt_q   <= '0;
        end else begin
            rd_valid_q   <= 1'b0;
            rd_expired_q <= 1'b0;
            if (bus.re) begin
                if (in_range(bus.raddr) && live[bus.raddr]) begin
                    rd_q       <= mem[bus.raddr];
                    rd_valid_q <= 1'b1;
                end else begin
                    rd_q         <= 'x;
                    rd_expired_q <= 1'b1;
                end
            end
            ref_done_q <= bus.ref_en;
            ref_ok_q   <= ref_hit && (live[bus.ref_addr] ||
                                      (wr_hit && (bus.waddr == bus.ref_addr)));
            live_cnt_q <= live_cnt_d;
        end
    end

    always_comb begin
        live_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_cnt_d = live_cnt_d + (ADDR_W+1)'(live_d[i]);
        end
    end

    assign bus.rd         = rd_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_expired = rd_expired_q;
    assign bus.ref_done   = ref_done_q;
    assign bus.ref_ok     = ref_ok_q;
    assign bus.live_cnt   = live_cnt_q;

`ifdef GC_DRAM_RET_WARN_EN
    logic              warn_q, warn_d;
    logic [ADDR_W-1:0] warn_addr_q, warn_addr_d;

    // Scan from the top so the lowest near-expiry index wins.
    always_comb begin
        warn_d      = 1'b0;
        warn_addr_d = warn_addr_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (near_d[i]) begin
                warn_d      = 1'b1;
                warn_addr_d = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_q      <= 1'b0;
            warn_addr_q <= '0;
        end else begin
            warn_q      <= warn_d;
            warn_addr_q <= warn_addr_d;
        end
    end

    assign bus.warn      = warn_q;
    assign bus.warn_addr = warn_addr_q;
`else
    logic unused_near;
    assign unused_near   = ^near_d;
    assign bus.warn      = 1'b0;
    assign bus.warn_addr = '0;
`endif
endmodule
